steer_en: RTL and testbench



---
 rtl/steer_en_if.sv | 30 +++
 rtl/steer_en.sv | 124 ++++++++++++
 tb/tb_steer_en.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/steer_en_if.sv
`default_nettype none
// ============================================================================
// Module   : steer_en_if
// Brief    : Load-cell sample bus and steering-enable status for steer_en.
// Revision : 1.0 - initial release
// ============================================================================
interface steer_en_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        en_steer;
  logic        rider_off;

  modport master (
    output lft_ld,
    output rght_ld,
    output ld_vld,
    input  en_steer,
    input  rider_off
  );

  modport slave (
    input  lft_ld,
    input  rght_ld,
    input  ld_vld,
    output en_steer,
    output rider_off
  );
endinterface
`default_nettype wire

// File: rtl/steer_en.sv
`default_nettype none
// ============================================================================
// Module   : steer_en
// Brief    : Rider-presence detector and steering enable with weight
//            hysteresis, left/right balance check and settle timer.
// Revision : 1.0 - initial release
// ============================================================================
module steer_en #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter bit          FAST_SIM     = 1'b1
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  steer_en_if.slave  bus
);

  localparam int          C_TMR_W  = FAST_SIM ? 15 : 26;
  localparam logic [12:0] C_MIN_HI = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] C_MIN_LO = {1'b0, MIN_RIDER_WT - WT_HYST};
  localparam logic [C_TMR_W-1:0] C_TMR_ONE = {{(C_TMR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STEER = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [11:0]        r_lft_q;
  logic [11:0]        r_rght_q;
  logic [C_TMR_W-1:0] r_tmr;
  logic               r_en_steer;
  logic               r_rider_off;

  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic [12:0] w_diff13;
  logic        w_gt_min;
  logic        w_lt_min;
  logic        w_diff_gt_1_4;
  logic        w_diff_gt_15_16;
  logic        w_tmr_full;
  logic        w_tmr_clr;
  logic        w_tmr_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft_q  <= 12'h000;
      r_rght_q <= 12'h000;
    end else if (bus.ld_vld) begin
      r_lft_q  <= bus.lft_ld;
      r_rght_q <= bus.rght_ld;
    end
  end

  assign w_sum           = {1'b0, r_lft_q} + {1'b0, r_rght_q};
  assign w_diff          = (r_lft_q >= r_rght_q) ? (r_lft_q - r_rght_q) : (r_rght_q - r_lft_q);
  assign w_diff13        = {1'b0, w_diff};
  assign w_gt_min        = (w_sum > C_MIN_HI);
  assign w_lt_min        = (w_sum < C_MIN_LO);
  assign w_diff_gt_1_4   = (w_diff13 > (w_sum >> 2));
  assign w_diff_gt_15_16 = (w_diff13 > (w_sum - (w_sum >> 4)));
  assign w_tmr_full      = &r_tmr;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gt_min) begin
          w_state_nxt = S_WAIT;
          w_tmr_clr   = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_lt_min) begin
          w_state_nxt = S_IDLE;
        end else if (w_diff_gt_1_4) begin
          w_tmr_clr = 1'b1;
        end else if (w_tmr_full) begin
          w_state_nxt = S_STEER;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      S_STEER: begin
        if (w_lt_min) begin
          w_state_nxt = S_IDLE;
        end else if (w_diff_gt_15_16) begin
          w_state_nxt = S_WAIT;
          w_tmr_clr   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_en_steer  <= 1'b0;
      r_rider_off <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_en_steer  <= (w_state_nxt == S_STEER);
      r_rider_off <= (w_state_nxt == S_IDLE);
      if (w_tmr_clr) begin
        r_tmr <= '0;
      end else if (w_tmr_inc) begin
        r_tmr <= r_tmr + C_TMR_ONE;
      end
    end
  end

  assign bus.en_steer  = r_en_steer;
  assign bus.rider_off = r_rider_off;

endmodule
`default_nettype wire

// File: tb/tb_steer_en.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_en
// Brief    : Self-checking bench for steer_en against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_steer_en;

  localparam int TMR_MAX = 32767;
  localparam int WT_HI   = 'h200;
  localparam int WT_LO   = 'h1C0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  steer_en_if bus ();

  steer_en #(
    .MIN_RIDER_WT (12'h200),
    .WT_HYST      (12'h040),
    .FAST_SIM     (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int m_l, m_r, m_settle;
  bit m_present, m_enabled;

  logic [11:0] cur_l, cur_r;
  logic        prev_en, prev_off;
  int en_rise_edge, en_fall_edge, off_fall_edge, off_rise_edge, first_vld_edge;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: rider present / steering enabled flags plus a settle count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_l = 0; m_r = 0; m_settle = 0; m_present = 1'b0; m_enabled = 1'b0;
    end else begin
      int s, d;
      s = m_l + m_r;
      d = (m_l > m_r) ? (m_l - m_r) : (m_r - m_l);
      if (!m_present) begin
        if (s > WT_HI) begin m_present = 1'b1; m_settle = 0; end
      end else if (!m_enabled) begin
        if (s < WT_LO) m_present = 1'b0;
        else if (d > s / 4) m_settle = 0;
        else if (m_settle == TMR_MAX) m_enabled = 1'b1;
        else m_settle = m_settle + 1;
      end else begin
        if (s < WT_LO) begin m_present = 1'b0; m_enabled = 1'b0; end
        else if (d > s - s / 16) begin m_enabled = 1'b0; m_settle = 0; end
      end
      if (bus.ld_vld) begin m_l = int'(bus.lft_ld); m_r = int'(bus.rght_ld); end
    end
  end

  task automatic run_cycles(input int n, input int period, input string tag);
    bit stop;
    stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!stop) begin
        checks++;
        if (bus.en_steer !== m_enabled || bus.rider_off !== !m_present) begin
          $display("FAIL %s cycle %0d: en_steer=%b rider_off=%b, expected en_steer=%b rider_off=%b",
                   tag, cyc, bus.en_steer, bus.rider_off, m_enabled, !m_present);
          failures++;
          stop = 1'b1;
        end
      end
      if (bus.en_steer === 1'b1 && prev_en === 1'b0) en_rise_edge = cyc;
      if (bus.en_steer === 1'b0 && prev_en === 1'b1) en_fall_edge = cyc;
      if (bus.rider_off === 1'b0 && prev_off === 1'b1) off_fall_edge = cyc;
      if (bus.rider_off === 1'b1 && prev_off === 1'b0) off_rise_edge = cyc;
      prev_en  = bus.en_steer;
      prev_off = bus.rider_off;
      bus.lft_ld  = cur_l;
      bus.rght_ld = cur_r;
      bus.ld_vld  = 1'b0;
      if (period > 0) begin
        if (i % period == 0) bus.ld_vld = 1'b1;
      end
      if (i == 0 && bus.ld_vld) first_vld_edge = cyc + 1;
    end
  endtask

  task automatic clear_edges();
    en_rise_edge = -1; en_fall_edge = -1; off_fall_edge = -1; off_rise_edge = -1;
    first_vld_edge = -1;
  endtask

  task automatic test_reset();
    bus.lft_ld = 12'h000; bus.rght_ld = 12'h000; bus.ld_vld = 1'b0;
    cur_l = 12'h000; cur_r = 12'h000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1) begin
      $display("FAIL reset_state: en_steer=%b rider_off=%b, expected 0/1", bus.en_steer, bus.rider_off);
      failures++;
    end
    rst_n = 1'b1;
    prev_en = bus.en_steer; prev_off = bus.rider_off;
    run_cycles(10, 5, "reset_pulse");
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1) begin
      $display("FAIL reset_idle: en_steer=%b rider_off=%b, expected 0/1", bus.en_steer, bus.rider_off);
      failures++;
    end
  endtask

  task automatic test_rider_on();
    clear_edges();
    cur_l = 12'h300; cur_r = 12'h300;
    run_cycles(33500, 1000, "rider_on");
    checks++;
    if (off_fall_edge != first_vld_edge + 1) begin
      $display("FAIL rider_off_fall: edge=%0d, expected %0d", off_fall_edge, first_vld_edge + 1);
      failures++;
    end
    checks++;
    if (en_rise_edge < 0 || en_rise_edge - off_fall_edge < 32766 || en_rise_edge - off_fall_edge > 32770) begin
      $display("FAIL settle_time: en rise %0d clk after rider detect, expected 32768", en_rise_edge - off_fall_edge);
      failures++;
    end
    checks++;
    if (bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      $display("FAIL steer_on: en_steer=%b rider_off=%b, expected 1/0", bus.en_steer, bus.rider_off);
      failures++;
    end
  endtask

  task automatic test_hysteresis_band();
    cur_l = 12'h0E0; cur_r = 12'h0F0;
    run_cycles(50, 10, "band");
    checks++;
    if (bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      $display("FAIL band_hold: en_steer=%b rider_off=%b, expected 1/0", bus.en_steer, bus.rider_off);
      failures++;
    end
  endtask

  task automatic test_single_foot();
    cur_l = 12'h600; cur_r = 12'h040;
    run_cycles(50, 10, "single_foot_ok");
    checks++;
    if (bus.en_steer !== 1'b1) begin
      $display("FAIL single_foot_hold: en_steer=%b, expected 1", bus.en_steer);
      failures++;
    end
    clear_edges();
    cur_l = 12'h600; cur_r = 12'h000;
    run_cycles(50, 10, "single_foot_drop");
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0 || en_fall_edge != first_vld_edge + 1) begin
      $display("FAIL single_foot_drop: en_steer=%b rider_off=%b fall_edge=%0d, expected 0/0 at %0d",
               bus.en_steer, bus.rider_off, en_fall_edge, first_vld_edge + 1);
      failures++;
    end
  endtask

  task automatic test_imbalance();
    cur_l = 12'h500; cur_r = 12'h100;
    run_cycles(3000, 1000, "imbalance");
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0) begin
      $display("FAIL imbalance_hold: en_steer=%b rider_off=%b, expected 0/0", bus.en_steer, bus.rider_off);
      failures++;
    end
    clear_edges();
    cur_l = 12'h300; cur_r = 12'h300;
    run_cycles(33500, 1000, "restore");
    checks++;
    if (en_rise_edge < 0 || en_rise_edge - first_vld_edge < 32766 || en_rise_edge - first_vld_edge > 32770) begin
      $display("FAIL restore_settle: en rise %0d clk after restore latch, expected 32768",
               en_rise_edge - first_vld_edge);
      failures++;
    end
  endtask

  task automatic test_step_off();
    clear_edges();
    cur_l = 12'h020; cur_r = 12'h010;
    run_cycles(20, 100, "step_off");
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1 ||
        en_fall_edge != first_vld_edge + 1 || off_rise_edge != first_vld_edge + 1) begin
      $display("FAIL step_off: en_steer=%b rider_off=%b en_fall=%0d off_rise=%0d, expected 0/1 at %0d",
               bus.en_steer, bus.rider_off, en_fall_edge, off_rise_edge, first_vld_edge + 1);
      failures++;
    end
  endtask

  task automatic test_thresholds();
    cur_l = 12'h100; cur_r = 12'h100;
    run_cycles(50, 10, "sum_eq_min");
    checks++;
    if (bus.rider_off !== 1'b1) begin
      $display("FAIL sum_eq_min: rider_off=%b, expected 1", bus.rider_off);
      failures++;
    end
    cur_l = 12'h101; cur_r = 12'h100;
    run_cycles(50, 10, "sum_above_min");
    checks++;
    if (bus.rider_off !== 1'b0 || bus.en_steer !== 1'b0) begin
      $display("FAIL sum_above_min: rider_off=%b en_steer=%b, expected 0/0", bus.rider_off, bus.en_steer);
      failures++;
    end
    cur_l = 12'h0E0; cur_r = 12'h0E0;
    run_cycles(50, 10, "sum_eq_low");
    checks++;
    if (bus.rider_off !== 1'b0) begin
      $display("FAIL sum_eq_low: rider_off=%b, expected 0", bus.rider_off);
      failures++;
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rider_off !== 1'b1 || bus.en_steer !== 1'b0) begin
      $display("FAIL async_reset: rider_off=%b en_steer=%b, expected 1/0 before clk", bus.rider_off, bus.en_steer);
      failures++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_en = bus.en_steer; prev_off = bus.rider_off;
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      cur_l = 12'($urandom_range(0, 'h3FF));
      cur_r = 12'($urandom_range(0, 'h3FF));
      run_cycles(60, int'($urandom_range(1, 8)), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 200; k++) begin
      cur_l = 12'($urandom_range(0, 'h2FF));
      cur_r = 12'($urandom_range(0, 'h2FF));
      run_cycles(1, 1, "back_to_back");
    end
    cur_l = 12'h000; cur_r = 12'h000;
    run_cycles(10, 1, "back_to_back_tail");
  endtask

  initial begin
    test_reset();
    test_rider_on();
    test_hysteresis_band();
    test_single_foot();
    test_imbalance();
    test_step_off();
    test_thresholds();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
